dti_skid_buff: RTL and testbench

//  Full-throughput DTI pipeline stage that registers the backward (ready) path
//  as well as the forward (valid/data) path. It is the two-entry skid buffer

---
 rtl/dti_skid_buff.sv | 92 +++++++++
 tb/tb_dti_skid_buff.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dti_skid_buff.sv
// Two-entry skid buffer for a DTI valid/ready link: registers both the forward
// (valid/data) path and the backward (ready) path while sustaining one transfer per cycle.
module dti_skid_buff #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din_data,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [W-1:0] dout_data,
  output logic         dout_valid,
  input  logic         dout_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           in_rdy_q, in_rdy_d;
  logic           out_vld_q, out_vld_d;
  logic           xfer_in;
  logic           xfer_out;

  // Handshake flags and next-state decode; ready/valid flags are precomputed
  // from the next state so both ports come straight from flops.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    xfer_in   = din_valid && in_rdy_q;
    xfer_out  = out_vld_q && dout_ready;

    case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          main_d  = din_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (xfer_in && xfer_out) begin
          main_d = din_data;
        end else if (xfer_in) begin
          skid_d  = din_data;
          state_d = ST_FULL;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    in_rdy_d  = (state_d != ST_FULL);
    out_vld_d = (state_d != ST_EMPTY);
  end

  // Control state; reset drops anything buffered and ignores a coincident handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Payload registers carry no reset; dout_data is don't-care while dout_valid is low.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign din_ready  = in_rdy_q;
  assign dout_valid = out_vld_q;
  assign dout_data  = main_q;

endmodule

// File: tb/tb_dti_skid_buff.sv
// Bench for dti_skid_buff: a two-slot FIFO reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dti_skid_buff;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din_data;
  logic         din_valid;
  logic         din_ready;
  logic [W-1:0] dout_data;
  logic         dout_valid;
  logic         dout_ready;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] model_q[$];
  bit           stall_seen;
  logic [W-1:0] stall_data;

  dti_skid_buff #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an in-order store of at most two items.
  always @(posedge clk) begin
    if (rst) begin
      model_q.delete();
      stall_seen <= 1'b0;
    end else begin
      bit acc_in, acc_out;
      acc_in  = din_valid && (model_q.size() < 2);
      acc_out = dout_ready && (model_q.size() > 0);
      stall_seen <= dout_valid && !dout_ready;
      stall_data <= dout_data;
      if (acc_out) void'(model_q.pop_front());
      if (acc_in)  model_q.push_back(din_data);
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dout_valid", 32'(dout_valid), 32'(model_q.size() > 0));
      check("model_din_ready",  32'(din_ready),  32'(model_q.size() < 2));
      if (model_q.size() > 0)
        check("model_dout_data", 32'(dout_data), 32'(model_q[0]));
      if (stall_seen) begin
        check("stall_valid_hold", 32'(dout_valid), 32'd1);
        check("stall_data_hold",  32'(dout_data),  32'(stall_data));
      end
    end
  end

  initial begin
    int accepted;
    int cycles;
    bit acc;

    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (4) begin
      @(negedge clk);
      check("idle_valid", 32'(dout_valid), 32'd0);
      check("idle_ready", 32'(din_ready), 32'd1);
    end

    // Back-to-back stream 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin
        check("stream_data", 32'(dout_data), 32'(i - 1));
        check("stream_ready", 32'(din_ready), 32'd1);
      end
      din_data  = W'(i);
      din_valid = 1'b1;
      @(negedge clk);
    end
    check("stream_data_last", 32'(dout_data), 32'h08);
    din_valid = 1'b0;
    @(negedge clk);
    check("stream_drained", 32'(dout_valid), 32'd0);

    // Backpressure with 0xA, 0xB, 0xC
    dout_ready = 1'b0;
    din_data = 8'h0A; din_valid = 1'b1;
    @(negedge clk);
    check("bp_a_head", 32'(dout_data), 32'h0A);
    check("bp_a_ready", 32'(din_ready), 32'd1);
    din_data = 8'h0B;
    @(negedge clk);
    check("bp_full_ready", 32'(din_ready), 32'd0);
    check("bp_b_head", 32'(dout_data), 32'h0A);
    din_data = 8'h0C;
    @(negedge clk);
    check("bp_c_held_ready", 32'(din_ready), 32'd0);
    check("bp_c_head", 32'(dout_data), 32'h0A);
    // Mid-cycle toggle of dout_ready must not reach din_ready
    #2 dout_ready = 1'b1;
    #1 check("nocomb_ready_hi", 32'(din_ready), 32'd0);
    #1 dout_ready = 1'b0;
    #1 check("nocomb_ready_lo", 32'(din_ready), 32'd0);
    @(negedge clk);
    dout_ready = 1'b1;
    @(negedge clk);
    check("rel_b_head", 32'(dout_data), 32'h0B);
    check("rel_ready_back", 32'(din_ready), 32'd1);
    @(negedge clk);
    check("rel_c_head", 32'(dout_data), 32'h0C);
    din_valid = 1'b0;
    @(negedge clk);
    check("rel_drained", 32'(dout_valid), 32'd0);

    // Reset while full drops buffered items
    dout_ready = 1'b0;
    din_data = 8'h0A; din_valid = 1'b1;
    @(negedge clk);
    din_data = 8'h0B;
    @(negedge clk);
    check("rstfull_ready", 32'(din_ready), 32'd0);
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);
    dout_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_leak", 32'(dout_valid), 32'd0);
    end

    // Random traffic, producer holds data until accepted
    accepted = 0;
    cycles   = 0;
    acc      = 1'b1;
    while (accepted < 2000 && cycles < 20000) begin
      if (!din_valid || acc) begin
        din_valid = 1'($urandom_range(0, 1));
        din_data  = W'($urandom);
      end
      dout_ready = 1'($urandom_range(0, 1));
      acc = din_valid && din_ready;
      if (acc) accepted++;
      cycles++;
      @(negedge clk);
    end
    check("random_accept_count", 32'(accepted), 32'd2000);
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("random_drained", 32'(dout_valid), 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
